// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, PS/2 line levels/drives and status of ps2_host_tx.
// master = controller/bench side, slave = the transmitter.
interface ps2_host_tx_if;
    logic [7:0] CmdData;
    logic       CmdValid;
    logic       CmdReady;
    logic       PS2CLK_IN;
    logic       PS2DATA_IN;
    logic       PS2CLK_DRIVE_LOW;
    logic       PS2DATA_DRIVE_LOW;
    logic       Busy;
    logic       Done;
    logic       Ack;
    logic       Fail;

    modport master (
        output CmdData, CmdValid, PS2CLK_IN, PS2DATA_IN,
        input  CmdReady, PS2CLK_DRIVE_LOW, PS2DATA_DRIVE_LOW, Busy, Done, Ack, Fail
    );

    modport slave (
        input  CmdData, CmdValid, PS2CLK_IN, PS2DATA_IN,
        output CmdReady, PS2CLK_DRIVE_LOW, PS2DATA_DRIVE_LOW, Busy, Done, Ack, Fail
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte per handshake:
// inhibit, request-to-send, 8 data + odd parity + stop shifted out on device clock
// falling edges, then device ACK capture. Lines are only ever pulled low or released.
// Build option: define PS2_TX_RETRY_EN to retry a failed attempt up to MAX_RETRIES times.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input logic          CLK,
    input logic          RST,
    ps2_host_tx_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StInhibit, StRts, StShift, StAck, StWaitIdle, StFinish
    } state_t;

    state_t      state_q;
    logic [9:0]  frame_q;      // {stop, parity, data}, sent LSB first
    logic [3:0]  bit_q;
    logic [31:0] cnt_q;        // inhibit count, then timeout count
    logic        ack_seen_q;
    logic        clk_s1_q, clk_s2_q, clk_prev_q;
    logic        data_s1_q, data_s2_q;
    logic        clk_drive_q, data_drive_q;
    logic        ready_q, done_q, ack_q, fail_q;

    logic fall, lines_idle, timed, abort, fail_now, can_retry;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= bus.PS2CLK_IN;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= bus.PS2DATA_IN;
            data_s2_q  <= data_s1_q;
        end
    end

    // Edge, idle and abort decodes.
    always_comb begin
        fall       = clk_prev_q & ~clk_s2_q;
        lines_idle = clk_s2_q & data_s2_q;
        timed      = state_q inside {StRts, StShift, StAck, StWaitIdle};
        abort      = timed && (cnt_q == 32'd0) && !fall
                     && !(state_q == StWaitIdle && lines_idle);
        fail_now   = abort || (state_q == StFinish && !ack_seen_q);
    end

`ifdef PS2_TX_RETRY_EN
    logic [31:0] retry_q;

    assign can_retry = (retry_q < MAX_RETRIES);

    // Attempts used for the current command; cleared on each new handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retry_q <= 32'd0;
        end else if (state_q == StIdle && bus.CmdValid) begin
            retry_q <= 32'd0;
        end else if (fail_now && can_retry) begin
            retry_q <= retry_q + 32'd1;
        end
    end
`else
    // Single attempt only: retries are never granted, whatever MAX_RETRIES says.
    assign can_retry = (MAX_RETRIES == 32'd0) && 1'b0;
`endif

    // Main transfer FSM with registered line drives and status pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            ack_seen_q   <= 1'b0;
            clk_drive_q  <= 1'b0;
            data_drive_q <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            ack_q        <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            fail_q <= 1'b0;
            if (fail_now) begin
                data_drive_q <= 1'b0;
                ack_seen_q   <= 1'b0;
                bit_q        <= '0;
                if (can_retry) begin
                    // Same frame again, starting from a fresh inhibit.
                    state_q     <= StInhibit;
                    clk_drive_q <= 1'b1;
                    cnt_q       <= INHIBIT_CYCLES - 32'd1;
                end else begin
                    state_q     <= StIdle;
                    clk_drive_q <= 1'b0;
                    ready_q     <= 1'b1;
                    done_q      <= 1'b1;
                    fail_q      <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.CmdValid) begin
                            frame_q     <= {1'b1, ~^bus.CmdData, bus.CmdData};
                            cnt_q       <= INHIBIT_CYCLES - 32'd1;
                            clk_drive_q <= 1'b1;
                            ready_q     <= 1'b0;
                            bit_q       <= '0;
                            ack_seen_q  <= 1'b0;
                            state_q     <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == 32'd0) begin
                            clk_drive_q  <= 1'b0;
                            data_drive_q <= 1'b1;   // start bit
                            cnt_q        <= TIMEOUT_CYCLES - 32'd1;
                            state_q      <= StRts;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    StRts: begin
                        if (fall) begin
                            data_drive_q <= ~frame_q[0];
                            bit_q        <= 4'd1;
                            cnt_q        <= TIMEOUT_CYCLES - 32'd1;
                            state_q      <= StShift;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    StShift: begin
                        if (fall) begin
                            data_drive_q <= ~frame_q[bit_q];
                            cnt_q        <= TIMEOUT_CYCLES - 32'd1;
                            if (bit_q == 4'd9) begin
                                state_q <= StAck;   // stop bit now on the line
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    StAck: begin
                        if (fall) begin
                            ack_seen_q <= ~data_s2_q;
                            cnt_q      <= TIMEOUT_CYCLES - 32'd1;
                            state_q    <= StWaitIdle;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    StWaitIdle: begin
                        if (lines_idle) begin
                            state_q <= StFinish;
                        end else if (fall) begin
                            cnt_q <= TIMEOUT_CYCLES - 32'd1;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    StFinish: begin
                        // NACK is handled by fail_now; only the ACK case lands here.
                        done_q  <= 1'b1;
                        ack_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.CmdReady          = ready_q;
    assign bus.Busy              = ~ready_q;
    assign bus.PS2CLK_DRIVE_LOW  = clk_drive_q;
    assign bus.PS2DATA_DRIVE_LOW = data_drive_q;
    assign bus.Done              = done_q;
    assign bus.Ack               = ack_q;
    assign bus.Fail              = fail_q;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-side PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) from the controller to the mouse over the bidirectional PS2CLK/PS2DATA lines.
- Implements the host-to-device direction: inhibit, request-to-send, data/parity/stop shift-out on device clock edges, and ACK capture.
- Sits beside the host mouse receiver. Its open-drain drive outputs are wired to the same lines the PS2MOUSE device model drives.

Parameters:
- INHIBIT_CYCLES, 10000, clock-low hold before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, maximum CLK cycles between device clock falling edges, and from RTS to the first edge, before abort (20 ms).
- MAX_RETRIES, 2, extra attempts after a failure; used only with PS2_TX_RETRY_EN.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- CmdData  in  8  command byte, sampled when CmdValid && CmdReady.
- CmdValid  in  1  command request.
- CmdReady  out  1  high only in IDLE.
- PS2CLK_IN  in  1  resolved PS2CLK line level.
- PS2DATA_IN  in  1  resolved PS2DATA line level.
- PS2CLK_DRIVE_LOW  out  1  1 = pull PS2CLK low, 0 = release (high-Z).
- PS2DATA_DRIVE_LOW  out  1  1 = pull PS2DATA low, 0 = release.
- Busy  out  1  transfer in progress (not IDLE).
- Done  out  1  one-cycle pulse at the end of every attempt sequence.
- Ack  out  1  valid with Done; 1 = device ACK seen.
- Fail  out  1  one-cycle pulse with Done on timeout or missing ACK.

Behaviour:
- Reset values: CmdReady=1, both DRIVE_LOW=0, Busy=0, Done=0, Ack=0, Fail=0. State=IDLE, all counters and the shift register cleared.
- Reset asserted mid-transfer releases both lines on the same edge; no partial frame continues.
- Input synchronisation:
  - PS2CLK_IN and PS2DATA_IN pass through 2-flop synchronisers.
  - A falling edge is registered sync state 1 followed by 0.
  - The edge is usable 3 CLK cycles after the line changes.
- Frame register: {stop=1, parity=~^CmdData (odd parity), CmdData} is captured on handshake and shifted LSB first.
- FSM:
  - IDLE: CmdReady=1. On CmdValid, latch the frame -> INHIBIT. CmdValid while Busy is ignored (CmdReady=0).
  - INHIBIT: PS2CLK_DRIVE_LOW=1 for exactly INHIBIT_CYCLES cycles -> RTS.
  - RTS: PS2DATA_DRIVE_LOW=1 (start bit 0) and PS2CLK released. Wait for the first device clock falling edge -> SHIFT.
  - SHIFT: on each falling edge, present the next frame bit (DRIVE_LOW = ~bit): bits 0-7, then parity, then stop (released). After the stop bit is presented, the next falling edge -> ACK.
  - ACK: sample PS2DATA on that 11th falling edge; 0 = ACK. -> WAIT_IDLE.
  - WAIT_IDLE: wait until both synced lines are high -> FINISH.
  - FINISH: pulse Done; Ack = sampled value; Fail = !ack -> IDLE.
- Timeout: the counter reloads on every falling edge and on RTS entry.
  - Expiry in RTS, SHIFT, ACK or WAIT_IDLE releases both lines.
  - Then pulses Done=1, Ack=0, Fail=1 -> IDLE.
- Lines are never driven high, only pulled low or released.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - On timeout or NACK, the block re-enters INHIBIT with the same frame, up to MAX_RETRIES times.
  - Done/Fail pulse only after the final attempt.
  - Busy stays high across retries.
- PS2_TX_RETRY_EN undefined: a single attempt, and MAX_RETRIES is ignored.

Test Plan:
- Send 0xF4 with the device model clocking at 12.5 kHz:
  - PS2DATA bit sequence start 0, then 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Device ACK low gives Done=1, Ack=1, Fail=0.
- Send 0xFF: eight 1 data bits, parity bit 1, Ack=1.
- No device clock after RTS: Done=1, Fail=1 exactly TIMEOUT_CYCLES cycles after RTS entry, both DRIVE_LOW=0.
- Device leaves PS2DATA high on the 11th edge: Done=1, Ack=0, Fail=1.
  - With PS2_TX_RETRY_EN, exactly 3 INHIBIT phases are seen before Done.
- Assert RST during bit 4: both DRIVE_LOW drop to 0 immediately and CmdReady=1.
  - A new 0xF4 command then completes with Ack=1.
- Pulse CmdValid with 0xAA during a transfer: ignored, and the current frame is unchanged.
- PS2CLK_DRIVE_LOW is held for INHIBIT_CYCLES ±0 cycles.
